// File: rtl/expon.sv
// expon - fixed-point exponential unit, y = e^x0.
//
// Range reduction splits x into e*ln2 + r.
// A shift-and-add loop then evaluates e^r.
// The result is scaled by 2^e, rounded and saturated.
//
// Ports
//   clk    rising-edge clock
//   rst    synchronous, active-high reset
//   start  one-cycle request, accepted in IDLE or DONE
//   x0     operand, signed Q2.8
//   y      result, unsigned Q2.8, saturated at 0x3FF
//   done   high while y holds a valid result
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start after reset
// NORM  | pick e, reduce z into [0, ln2)
// ITER  | 6 cycles, two shift-and-add steps per cycle (k = 1..12)
// FINAL | scale by 2^e, round, saturate into y, raise done
// DONE  | hold y/done; start begins a new computation
module expon (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [9:0] x0,
    output logic [9:0] y,
    output logic       done
);

    typedef enum logic [2:0] {IDLE, NORM, ITER, FINAL, DONE} state_t;

    localparam logic signed [14:0] LN2 = 15'sd2839;

    state_t             state, state_n;
    logic signed [14:0] z, z_n;
    logic        [17:0] p, p_n;
    logic signed [2:0]  e, e_n;
    logic        [2:0]  cnt, cnt_n;
    logic        [9:0]  y_n;
    logic               done_n;

    // ln(1 + 2^-k) in Q.12
    function automatic logic [10:0] lk(input logic [3:0] k);
        case (k)
            4'd1:    lk = 11'd1661;
            4'd2:    lk = 11'd914;
            4'd3:    lk = 11'd482;
            4'd4:    lk = 11'd248;
            4'd5:    lk = 11'd126;
            4'd6:    lk = 11'd64;
            4'd7:    lk = 11'd32;
            4'd8:    lk = 11'd16;
            4'd9:    lk = 11'd8;
            4'd10:   lk = 11'd4;
            4'd11:   lk = 11'd2;
            4'd12:   lk = 11'd1;
            default: lk = 11'd0;
        endcase
    endfunction

    // Range reduction: largest e in [-3, 2] with e*ln2 <= z.
    logic signed [2:0]  norm_e;
    logic signed [14:0] norm_off;

    always_comb begin
        norm_e   = -3'sd3;
        norm_off = -15'sd8517;
        if (z >= 2 * LN2) begin
            norm_e   = 3'sd2;
            norm_off = 15'sd5678;
        end else if (z >= LN2) begin
            norm_e   = 3'sd1;
            norm_off = LN2;
        end else if (z >= 15'sd0) begin
            norm_e   = 3'sd0;
            norm_off = 15'sd0;
        end else if (z >= -LN2) begin
            norm_e   = -3'sd1;
            norm_off = -LN2;
        end else if (z >= -2 * LN2) begin
            norm_e   = -3'sd2;
            norm_off = -15'sd5678;
        end
    end

    // Two chained steps per ITER cycle.
    // Cycle cnt handles k = 2*cnt+1 and 2*cnt+2.
    logic        [3:0]  k_a, k_b;
    logic signed [14:0] l_a, l_b;
    logic signed [14:0] z_a, z_b;
    logic        [17:0] p_a, p_b;

    always_comb begin
        k_a = {cnt, 1'b0} + 4'd1;
        k_b = k_a + 4'd1;
        l_a = $signed({4'b0000, lk(k_a)});
        l_b = $signed({4'b0000, lk(k_b)});
        z_a = z;
        p_a = p;
        if (z >= l_a) begin
            z_a = z - l_a;
            p_a = p + (p >> k_a);
        end
        z_b = z_a;
        p_b = p_a;
        if (z_a >= l_b) begin
            z_b = z_a - l_b;
            p_b = p_a + (p_a >> k_b);
        end
    end

    // Final scaling with round-half-up, saturated to 10 bits.
    logic [19:0] v;
    logic [2:0]  neg_e;

    always_comb begin
        neg_e = 3'd0 - e;
        if (!e[2])
            v = ((20'(p) << e[1:0]) + 20'd8) >> 4;
        else
            v = (20'(p) + (20'd1 << (4'(neg_e) + 4'd3))) >> (4'(neg_e) + 4'd4);
    end

    always_comb begin
        state_n = state;
        z_n     = z;
        p_n     = p;
        e_n     = e;
        cnt_n   = cnt;
        y_n     = y;
        done_n  = done;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    z_n     = {x0[9], x0, 4'b0000};
                    p_n     = 18'd4096;
                    cnt_n   = 3'd0;
                    done_n  = 1'b0;
                    state_n = NORM;
                end
            end
            NORM: begin
                e_n     = norm_e;
                z_n     = z - norm_off;
                cnt_n   = 3'd0;
                state_n = ITER;
            end
            ITER: begin
                z_n   = z_b;
                p_n   = p_b;
                cnt_n = cnt + 3'd1;
                if (cnt == 3'd5)
                    state_n = FINAL;
            end
            FINAL: begin
                y_n     = (v > 20'd1023) ? 10'h3FF : v[9:0];
                done_n  = 1'b1;
                state_n = DONE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            z     <= '0;
            p     <= '0;
            e     <= '0;
            cnt   <= '0;
            y     <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            z     <= z_n;
            p     <= p_n;
            e     <= e_n;
            cnt   <= cnt_n;
            y     <= y_n;
            done  <= done_n;
        end
    end

endmodule

// File: tb/tb_expon.sv
// tb_expon - directed test for expon.
// Expected results are worked out by hand from the algorithm.
module tb_expon;

    logic       clk;
    logic       rst;
    logic       start;
    logic [9:0] x0;
    logic [9:0] y;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;
    int prev_y   = 0;

    expon dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x0    (x0),
        .y     (y),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns the number of edges until done rises, or -1 after 20 edges.
    task automatic wait_done(output int lat);
        bit seen;
        seen = 1'b0;
        lat  = -1;
        for (int i = 1; i <= 20; i++) begin
            if (!seen) begin
                tick();
                if (done) begin
                    seen = 1'b1;
                    lat  = i;
                end
            end
        end
    endtask

    task automatic run_op(input logic [9:0] a, input int exp_y, input string tag);
        int lat;
        x0    = a;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_val({tag, "_accept_done"}, int'(done), 0);
        check_val({tag, "_accept_yold"}, int'(y), prev_y);
        wait_done(lat);
        check_val({tag, "_latency"}, lat, 8);
        check_val({tag, "_y"}, int'(y), exp_y);
        prev_y = exp_y;
    endtask

    initial begin
        int lat;
        int edges;
        rst   = 1'b1;
        start = 1'b0;
        x0    = '0;
        tick();
        tick();
        check_val("reset_y", int'(y), 0);
        check_val("reset_done", int'(done), 0);
        rst = 1'b0;
        tick();

        run_op(10'h000, 256,  "zero");
        run_op(10'h300, 94,   "neg1");
        run_op(10'h100, 696,  "pos1");
        run_op(10'h200, 35,   "neg2");
        run_op(10'h1FF, 1023, "sat");
        run_op(10'h3FF, 255,  "neg_lsb");

        // start and operand changes during ITER are ignored
        x0    = 10'h100;
        start = 1'b1;
        tick();
        start = 1'b0;
        edges = 0;
        repeat (3) begin
            tick();
            edges++;
        end
        x0    = 10'h200;
        start = 1'b1;
        tick();
        edges++;
        start = 1'b0;
        wait_done(lat);
        check_val("ignore_latency", (lat < 0) ? -1 : edges + lat, 8);
        check_val("ignore_y", int'(y), 696);
        prev_y = 696;

        // reset during ITER aborts the computation
        x0    = 10'h300;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        check_val("midrst_y", int'(y), 0);
        check_val("midrst_done", int'(done), 0);
        rst = 1'b0;
        repeat (10) tick();
        check_val("midrst_stays_idle", int'(done), 0);
        prev_y = 0;
        run_op(10'h000, 256, "after_rst");

        // back-to-back request straight from DONE
        run_op(10'h300, 94, "b2b");

        // start held high restarts a computation every 9 cycles
        x0    = 10'h3FF;
        start = 1'b1;
        tick();
        wait_done(lat);
        check_val("hold_first_latency", lat, 8);
        check_val("hold_first_y", int'(y), 255);
        tick();
        check_val("hold_restart_done", int'(done), 0);
        wait_done(lat);
        check_val("hold_period", (lat < 0) ? -1 : lat + 1, 9);
        check_val("hold_second_y", int'(y), 255);

        // rst wins over start on the same edge
        rst = 1'b1;
        tick();
        check_val("rst_over_start_done", int'(done), 0);
        check_val("rst_over_start_y", int'(y), 0);
        rst   = 1'b0;
        start = 1'b0;
        repeat (10) tick();
        check_val("rst_over_start_idle", int'(done), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
